spart_bus_ctrl: RTL and testbench

Sequencer and arbiter for one SPART instance (baud generator, transmitter, receiver) sharing a single `ioaddr`/`databus`/`iorw` bus. After reset it programs the baud divisor. It then multiplexes the bus between two transmit requesters and the receive path, giving receive reads priority so that no byte is lost. It sits between the system-side producers and consumers and the SPART register interface.

---
 rtl/spart_bus_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_spart_bus_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_ctrl.sv
// Bus sequencer/arbiter for one SPART: programs the baud divisor, then shares the
// ioaddr/databus/iorw bus between two transmit requesters and the receive path.
module spart_bus_ctrl #(
  parameter logic [7:0] DIV_LO     = 8'h05,
  parameter logic [7:0] DIV_HI     = 8'h00,
  parameter int         TX_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [1:0] ioaddr,
  output logic       iorw,
  output logic [7:0] dbus_out,
  input  logic [7:0] dbus_in,
  input  logic       tbr,
  input  logic       rda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cfg_done,
  output logic       tx_err
);

  localparam int CNT_W = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    CFG_LO, CFG_HI, IDLE, TX_WR, TX_WAIT_LO, TX_WAIT_HI, RX_RD, RX_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ioaddr_q, ioaddr_d;
  logic             iorw_q, iorw_d;
  logic [7:0]       dbus_out_q, dbus_out_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             cfg_done_q, cfg_done_d;
  logic             tx_err_q, tx_err_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick1;
  logic [7:0]       tx_byte;

  always_comb begin
    // With both requesting, the one not granted last time wins.
    pick1   = req1 & ~(req0 & last_q);
    tx_byte = pick1 ? data1 : data0;

    state_d    = state_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cfg_done_d = cfg_done_q;
    tx_err_d   = tx_err_q;
    last_d     = last_q;
    cnt_d      = cnt_q;

    case (state_q)
      CFG_LO: begin
        // Outputs lag the state by a register; leave only once the low-byte write is on the bus.
        if (ioaddr_q == 2'b10 && !iorw_q) state_d = CFG_HI;
      end
      CFG_HI: begin
        state_d    = IDLE;
        cfg_done_d = 1'b1;
      end
      IDLE: begin
        if (rda) begin
          state_d = RX_RD;
        end else if (cfg_done_q && tbr && (req0 || req1)) begin
          state_d = TX_WR;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          last_d  = pick1;
        end
      end
      TX_WR: begin
        cnt_d   = CNT_W'(TX_TIMEOUT);
        state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!tbr) begin
          state_d = TX_WAIT_HI;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
        end
      end
      TX_WAIT_HI: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (tbr) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
        end
      end
      RX_RD: begin
        rx_data_d  = dbus_in;
        rx_valid_d = 1'b1;
        state_d    = RX_WAIT;
      end
      RX_WAIT: begin
        if (!rda) state_d = IDLE;
      end
      default: state_d = CFG_LO;
    endcase

    // Bus outputs are decoded from the next state so they are registered with it.
    ioaddr_d   = 2'b01;
    iorw_d     = 1'b1;
    dbus_out_d = 8'h00;
    case (state_d)
      CFG_LO: begin
        ioaddr_d   = 2'b10;
        iorw_d     = 1'b0;
        dbus_out_d = DIV_LO;
      end
      CFG_HI: begin
        ioaddr_d   = 2'b11;
        iorw_d     = 1'b0;
        dbus_out_d = DIV_HI;
      end
      TX_WR: begin
        ioaddr_d   = 2'b00;
        iorw_d     = 1'b0;
        dbus_out_d = tx_byte;
      end
      RX_RD: begin
        ioaddr_d = 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG_LO;
      ioaddr_q   <= 2'b00;
      iorw_q     <= 1'b1;
      dbus_out_q <= 8'h00;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      cfg_done_q <= 1'b0;
      tx_err_q   <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ioaddr_q   <= ioaddr_d;
      iorw_q     <= iorw_d;
      dbus_out_q <= dbus_out_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cfg_done_q <= cfg_done_d;
      tx_err_q   <= tx_err_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ioaddr   = ioaddr_q;
  assign iorw     = iorw_q;
  assign dbus_out = dbus_out_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cfg_done = cfg_done_q;
  assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: table of transmit vectors plus hand-written
// configuration, receive-priority, timeout and reset sequences, with scoreboards.
module tb_spart_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       gnt0, gnt1;
  logic [1:0] ioaddr;
  logic       iorw;
  logic [7:0] dbus_out;
  logic [7:0] dbus_in = 8'h00;
  logic       tbr;
  logic       rda = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cfg_done;
  logic       tx_err;

  logic tbr_auto = 1'b1;
  logic tbr_man  = 1'b1;
  logic tbr_mdl  = 1'b1;
  int   tbr_cnt  = 0;
  assign tbr = tbr_auto ? tbr_mdl : tbr_man;

  always #5 clk = ~clk;

  spart_bus_ctrl #(.TX_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ioaddr(ioaddr), .iorw(iorw), .dbus_out(dbus_out), .dbus_in(dbus_in),
    .tbr(tbr), .rda(rda),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .cfg_done(cfg_done), .tx_err(tx_err)
  );

  typedef struct {
    logic       who;
    logic [7:0] dat;
  } sb_t;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       who;
    logic [7:0] dat;
  } vec_t;

  sb_t        tx_q[$];
  logic [7:0] rx_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge, then score DUT outputs and run the SPART tbr model.
  task automatic tick();
    sb_t e;
    logic [7:0] r;
    @(negedge clk);
    if (!rst) begin
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        if (tx_q.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt1), 32'hdead);
        end else begin
          e = tx_q.pop_front();
          chk("gnt_who", 32'(gnt1), 32'(e.who));
          chk("gnt_data", 32'(dbus_out), 32'(e.dat));
          chk("gnt_bus", 32'({ioaddr, iorw}), 32'd0);
        end
      end
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", 32'(rx_data), 32'hdead);
        end else begin
          r = rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(r));
        end
      end
    end
    if (tbr_auto) begin
      if (tbr_cnt > 0) begin
        tbr_cnt--;
        if (tbr_cnt == 0) tbr_mdl = 1'b1;
      end else if (!rst && ioaddr == 2'b00 && !iorw) begin
        tbr_mdl = 1'b0;
        tbr_cnt = 2;
      end
    end
  endtask

  task automatic wait_gnt(input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      seen = gnt0 | gnt1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic chk_cfg(input string nm);
    tick();
    chk({nm, "_lo_addr"}, 32'(ioaddr), 32'd2);
    chk({nm, "_lo_data"}, 32'(dbus_out), 32'h05);
    chk({nm, "_lo_rw"}, 32'(iorw), 32'd0);
    chk({nm, "_lo_done"}, 32'(cfg_done), 32'd0);
    chk({nm, "_lo_gnt"}, 32'({gnt0, gnt1}), 32'd0);
    tick();
    chk({nm, "_hi_addr"}, 32'(ioaddr), 32'd3);
    chk({nm, "_hi_data"}, 32'(dbus_out), 32'h00);
    chk({nm, "_hi_rw"}, 32'(iorw), 32'd0);
    chk({nm, "_hi_done"}, 32'(cfg_done), 32'd0);
    chk({nm, "_hi_gnt"}, 32'({gnt0, gnt1}), 32'd0);
    tick();
    chk({nm, "_done"}, 32'(cfg_done), 32'd1);
    chk({nm, "_idle_bus"}, 32'({ioaddr, iorw}), 32'b011);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_addr"}, 32'(ioaddr), 32'd0);
    chk({nm, "_rw"}, 32'(iorw), 32'd1);
    chk({nm, "_dbus"}, 32'(dbus_out), 32'd0);
    chk({nm, "_gnt"}, 32'({gnt0, gnt1}), 32'd0);
    chk({nm, "_rxd"}, 32'(rx_data), 32'd0);
    chk({nm, "_rxv"}, 32'(rx_valid), 32'd0);
    chk({nm, "_cfg"}, 32'(cfg_done), 32'd0);
    chk({nm, "_err"}, 32'(tx_err), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'hf3, 8'h11, 1'b0, 8'hf3};
    vecs[1] = '{1'b1, 1'b1, 8'hf3, 8'h11, 1'b1, 8'h11};
    vecs[2] = '{1'b1, 1'b1, 8'hf3, 8'h11, 1'b0, 8'hf3};
    vecs[3] = '{1'b1, 1'b1, 8'hf3, 8'h11, 1'b1, 8'h11};
    vecs[4] = '{1'b1, 1'b0, 8'h6a, 8'h00, 1'b0, 8'h6a};
    vecs[5] = '{1'b1, 1'b0, 8'h5c, 8'h00, 1'b0, 8'h5c};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'ha7, 1'b1, 8'ha7};
    vecs[7] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 8'h01};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h80, 1'b1, 8'h80};
    vecs[9] = '{1'b1, 1'b1, 8'hff, 8'h00, 1'b0, 8'hff};

    repeat (3) tick();
    chk_reset_vals("rst");

    // Requests held through configuration must not be granted early.
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hf3; data1 = 8'h11;
    chk_cfg("cfg");

    for (int i = 0; i < 10; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      data0 = vecs[i].d0; data1 = vecs[i].d1;
      tx_q.push_back('{vecs[i].who, vecs[i].dat});
      wait_gnt($sformatf("vec%0d_gnt", i));
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) tick();
      chk($sformatf("vec%0d_idle", i), 32'({ioaddr, iorw}), 32'b011);
      chk($sformatf("vec%0d_err", i), 32'(tx_err), 32'd0);
    end

    // Receive wins over a simultaneous request; the request is served afterwards.
    rda = 1'b1; dbus_in = 8'h6a; req1 = 1'b1; data1 = 8'hc4;
    rx_q.push_back(8'h6a);
    tx_q.push_back('{1'b1, 8'hc4});
    tick();
    chk("rx_rd_bus", 32'({ioaddr, iorw}), 32'b001);
    chk("rx_rd_nognt", 32'(gnt1), 32'd0);
    tick();
    chk("rx_valid_hi", 32'(rx_valid), 32'd1);
    chk("rx_data_val", 32'(rx_data), 32'h6a);
    dbus_in = 8'h00;
    tick();
    chk("rx_valid_pulse", 32'(rx_valid), 32'd0);
    chk("rx_wait_nognt", 32'(gnt1), 32'd0);
    rda = 1'b0;
    tick();
    chk("rx_back_nognt", 32'(gnt1), 32'd0);
    wait_gnt("rx_then_gnt1");
    req1 = 1'b0;
    repeat (3) tick();
    chk("rx_data_hold", 32'(rx_data), 32'h6a);

    // tbr never drops after the write: error after 15 wait cycles.
    tbr_auto = 1'b0; tbr_man = 1'b1;
    req0 = 1'b1; data0 = 8'h3c;
    tx_q.push_back('{1'b0, 8'h3c});
    wait_gnt("to_gnt");
    req0 = 1'b0;
    repeat (14) tick();
    tick();
    chk("to_err_before", 32'(tx_err), 32'd0);
    tick();
    chk("to_err_set", 32'(tx_err), 32'd1);
    chk("to_idle_bus", 32'({ioaddr, iorw}), 32'b011);
    tbr_auto = 1'b1;
    req1 = 1'b1; data1 = 8'h5a;
    tx_q.push_back('{1'b1, 8'h5a});
    wait_gnt("to_next_gnt");
    req1 = 1'b0;
    repeat (3) tick();
    chk("to_err_sticky", 32'(tx_err), 32'd1);

    // Reset while waiting for tbr to rise again.
    tbr_auto = 1'b0; tbr_man = 1'b1;
    req0 = 1'b1; data0 = 8'h99;
    tx_q.push_back('{1'b0, 8'h99});
    wait_gnt("mid_gnt");
    req0 = 1'b0; tbr_man = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("mid");
    rst = 1'b0; tbr_man = 1'b1; tbr_auto = 1'b1; tbr_mdl = 1'b1; tbr_cnt = 0;
    chk_cfg("recfg");
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h12; data1 = 8'h34;
    tx_q.push_back('{1'b0, 8'h12});
    wait_gnt("recfg_tie_gnt");
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    chk("tx_sb_empty", 32'(tx_q.size()), 32'd0);
    chk("rx_sb_empty", 32'(rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
